dist2_sorter_ctrl: RTL

//  Frame sequencer for the dist2Sorter datapath. Accepts complex-symbol quads
//  (4 x {real,imag}) on a valid/ready stream and clears the sorter. Steers each

---
 rtl/dist2_sorter_ctrl_if.sv | 33 +++
 rtl/dist2_sorter_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dist2_sorter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dist2_sorter_ctrl_if
// Brief    : Stream, sorter-steering and result handshake bundle for the
//            dist2Sorter frame sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface dist2_sorter_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int N_LOAD = 4
);
    logic                 s_valid;
    logic                 s_ready;
    logic [8*WIDTH-1:0]   s_data;
    logic [8*WIDTH-1:0]   sort_data;
    logic [N_LOAD-1:0]    load;
    logic                 sort_clr;
    logic                 m_valid;
    logic                 m_ready;

    // Controller side: consumes quads, drives the sorter and the result valid
    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, sort_data, load, sort_clr, m_valid
    );

    // Environment side: quad source, sorter and downstream detector
    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, sort_data, load, sort_clr, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/dist2_sorter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dist2_sorter_ctrl
// Brief    : Frame sequencer for the dist2Sorter datapath. Clears the sorter,
//            steers N_LOAD symbol quads into it with a one-hot load strobe,
//            waits the sort latency and offers the result downstream.
//            Optional feature macro: CTRL_ABORT_EN (adds the abort input).
// Revision : 1.0  initial release
// ============================================================================
module dist2_sorter_ctrl #(
    parameter int WIDTH    = 16,
    parameter int N_LOAD   = 4,
    parameter int SORT_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    dist2_sorter_ctrl_if.master     bus,
    output logic                    busy,
    output logic [15:0]             frame_cnt
`ifdef CTRL_ABORT_EN
    ,
    input  logic                    abort
`endif
);

    localparam int              c_IDX_W     = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_LOAD - 1);
    localparam logic [3:0]      c_LAST_WAIT = 4'(SORT_LAT - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_CLEAR = 3'd1;
    localparam logic [2:0] c_S_LOAD  = 3'd2;
    localparam logic [2:0] c_S_WAIT  = 3'd3;
    localparam logic [2:0] c_S_OUT   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_nextState;
    logic [c_IDX_W-1:0]  r_slotIdx;
    logic [c_IDX_W-1:0]  w_nSlotIdx;
    logic [3:0]          r_waitCnt;
    logic [3:0]          w_nWaitCnt;
    logic [8*WIDTH-1:0]  r_sortData;
    logic [8*WIDTH-1:0]  w_nSortData;
    logic [N_LOAD-1:0]   r_load;
    logic [N_LOAD-1:0]   w_nLoad;
    logic                r_sortClr;
    logic                w_nSortClr;
    logic                r_sReady;
    logic                w_nSReady;
    logic                r_mValid;
    logic                w_nMValid;
    logic                r_busy;
    logic                w_nBusy;
    logic [15:0]         r_frameCnt;
    logic [15:0]         w_nFrameCnt;

    logic                w_sHs;
    logic                w_mHs;
    logic                w_abort;

    // s_ready is only ever high in LOAD, m_valid only in OUT
    assign w_sHs = r_sReady && bus.s_valid;
    assign w_mHs = r_mValid && bus.m_ready;

`ifdef CTRL_ABORT_EN
    // Abort is meaningless while idle; elsewhere it pre-empts every handshake
    assign w_abort = abort && (r_state != c_S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // State and all output/datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_slotIdx  <= '0;
            r_waitCnt  <= '0;
            r_sortData <= '0;
            r_load     <= '0;
            r_sortClr  <= 1'b0;
            r_sReady   <= 1'b0;
            r_mValid   <= 1'b0;
            r_busy     <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_slotIdx  <= w_nSlotIdx;
            r_waitCnt  <= w_nWaitCnt;
            r_sortData <= w_nSortData;
            r_load     <= w_nLoad;
            r_sortClr  <= w_nSortClr;
            r_sReady   <= w_nSReady;
            r_mValid   <= w_nMValid;
            r_busy     <= w_nBusy;
            r_frameCnt <= w_nFrameCnt;
        end
    end

    // Frame sequencing: IDLE -> CLEAR -> LOAD -> WAIT -> OUT -> IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.s_valid)                            w_nextState = c_S_CLEAR;
            c_S_CLEAR:                                             w_nextState = c_S_LOAD;
            c_S_LOAD:  if (w_sHs && (r_slotIdx == c_LAST_IDX))     w_nextState = c_S_WAIT;
            c_S_WAIT:  if (r_waitCnt == c_LAST_WAIT)               w_nextState = c_S_OUT;
            c_S_OUT:   if (w_mHs)                                  w_nextState = c_S_IDLE;
            default:                                               w_nextState = c_S_IDLE;
        endcase
        if (w_abort) begin
            w_nextState = c_S_CLEAR;
        end
    end

    // Next values of the registered outputs; flags follow the state being entered
    always_comb begin
        w_nLoad     = '0;
        w_nSortClr  = (w_nextState == c_S_CLEAR);
        w_nSReady   = (w_nextState == c_S_LOAD);
        w_nMValid   = (w_nextState == c_S_OUT);
        w_nBusy     = (w_nextState != c_S_IDLE);
        w_nSortData = r_sortData;
        w_nSlotIdx  = r_slotIdx;
        w_nWaitCnt  = r_waitCnt;
        w_nFrameCnt = r_frameCnt;
        case (r_state)
            c_S_CLEAR: begin
                w_nSlotIdx = '0;
            end
            c_S_LOAD: begin
                // WAIT counts from the cycle the last strobe is on the bus
                w_nWaitCnt = '0;
                if (w_sHs) begin
                    w_nSortData = bus.s_data;
                    w_nLoad     = N_LOAD'(1) << r_slotIdx;
                    w_nSlotIdx  = r_slotIdx + c_IDX_W'(1);
                end
            end
            c_S_WAIT: begin
                w_nWaitCnt = r_waitCnt + 4'd1;
            end
            c_S_OUT: begin
                if (w_mHs) begin
                    w_nFrameCnt = r_frameCnt + 16'd1;
                end
            end
            default: begin
                w_nSlotIdx = r_slotIdx;
            end
        endcase
        // Abort discards the frame: no strobe, no count, data held
        if (w_abort) begin
            w_nLoad     = '0;
            w_nSortData = r_sortData;
            w_nSlotIdx  = '0;
            w_nWaitCnt  = '0;
            w_nFrameCnt = r_frameCnt;
        end
    end

    assign bus.s_ready   = r_sReady;
    assign bus.sort_data = r_sortData;
    assign bus.load      = r_load;
    assign bus.sort_clr  = r_sortClr;
    assign bus.m_valid   = r_mValid;
    assign busy          = r_busy;
    assign frame_cnt     = r_frameCnt;

endmodule
`default_nettype wire
